// File: rtl/c3aibadapt_rxdp_txeq_ntap_sm_pkg.sv
// Shared definitions for the N-tap TX-equalisation feedback engine:
// FSM state encodings, per-tap direction codes and the timer width helper.
package c3aibadapt_rxdp_txeq_ntap_sm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_DECIDE = 3'd2,
        ST_REPORT = 3'd3,
        ST_HOLD   = 3'd4
    } txeq_state_e;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_INC  = 2'b01;
    localparam logic [1:0] DIR_DEC  = 2'b10;

    // Window timer counts raw clock cycles: 8 bits of time units times the prescale.
    function automatic int txeq_tmr_w(input int prescale);
        return 8 + $clog2(prescale);
    endfunction

endpackage

// File: rtl/c3aibadapt_rxdp_txeq_ntap_sm_if.sv
// Configuration, PMA vote and feedback signals of the txeq engine.
// master = stimulus/controller side, slave = the engine itself.
interface c3aibadapt_rxdp_txeq_ntap_sm_if #(
    parameter int NTAP   = 3,
    parameter int COEF_W = 6
);
    logic                   r_rx_txeq_en;
    logic [NTAP-1:0]        r_rx_tap_en;
    logic                   r_rx_invalid_no_change;
    logic [1:0]             r_rx_eq_iteration;
    logic [7:0]             r_rx_txeq_time;
    logic                   rxeqinprogress;
    logic                   rxeqeval;
    logic                   invalid_req;
    logic [NTAP-1:0]        tap_up;
    logic [NTAP-1:0]        tap_dn;
    logic                   pma_tx_accum;
    logic                   phystatus;
    logic [2*NTAP-1:0]      dirfeedback;
    logic [COEF_W*NTAP-1:0] coef;
    logic                   timeout;
    logic [2:0]             st;

    modport master (
        output r_rx_txeq_en, r_rx_tap_en, r_rx_invalid_no_change, r_rx_eq_iteration,
               r_rx_txeq_time, rxeqinprogress, rxeqeval, invalid_req, tap_up, tap_dn,
        input  pma_tx_accum, phystatus, dirfeedback, coef, timeout, st
    );

    modport slave (
        input  r_rx_txeq_en, r_rx_tap_en, r_rx_invalid_no_change, r_rx_eq_iteration,
               r_rx_txeq_time, rxeqinprogress, rxeqeval, invalid_req, tap_up, tap_dn,
        output pma_tx_accum, phystatus, dirfeedback, coef, timeout, st
    );
endinterface

// File: rtl/c3aibadapt_rxdp_txeq_tap.sv
// One equalisation tap slice: saturating vote counter, direction decision,
// bounded coefficient tracker and a single-step undo record.
module c3aibadapt_rxdp_txeq_tap
    import c3aibadapt_rxdp_txeq_ntap_sm_pkg::*;
#(
    parameter int VOTE_W    = 16,
    parameter int COEF_W    = 6,
    parameter int COEF_INIT = 20,
    parameter int COEF_MIN  = 0,
    parameter int COEF_MAX  = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tap_en,
    input  logic              tap_up,
    input  logic              tap_dn,
    input  logic              clr_votes,
    input  logic              accum,
    input  logic              apply,
    input  logic              clr_fb,
    input  logic              undo,
    input  logic              revert,
    output logic [1:0]        dir,
    output logic [COEF_W-1:0] coef
);

    localparam logic [VOTE_W-1:0] VOTE_POS_MAX = {1'b0, {(VOTE_W-1){1'b1}}};
    localparam logic [VOTE_W-1:0] VOTE_NEG_MAX = {1'b1, {(VOTE_W-2){1'b0}}, 1'b1};
    localparam logic [VOTE_W-1:0] VOTE_ONE     = {{(VOTE_W-1){1'b0}}, 1'b1};
    localparam logic [VOTE_W-1:0] VOTE_ZERO    = {VOTE_W{1'b0}};
    localparam logic [COEF_W-1:0] COEF_ONE     = {{(COEF_W-1){1'b0}}, 1'b1};
    localparam logic [COEF_W-1:0] C_INIT       = COEF_W'(COEF_INIT);
    localparam logic [COEF_W-1:0] C_MIN        = COEF_W'(COEF_MIN);
    localparam logic [COEF_W-1:0] C_MAX        = COEF_W'(COEF_MAX);

    logic [VOTE_W-1:0] vote_r;
    logic [VOTE_W-1:0] vote_nxt_s;
    logic [1:0]        dec_s;
    logic [1:0]        dir_r;
    logic [1:0]        dir_nxt_s;
    logic [1:0]        step_r;
    logic [1:0]        step_nxt_s;
    logic [COEF_W-1:0] coef_r;
    logic [COEF_W-1:0] coef_nxt_s;

    // Saturating +1/-1 vote update; conflicting or absent votes leave it unchanged.
    always_comb begin
        vote_nxt_s = vote_r;
        if (tap_up && !tap_dn) begin
            if (vote_r != VOTE_POS_MAX) vote_nxt_s = vote_r + VOTE_ONE;
            else                        vote_nxt_s = vote_r;
        end else if (tap_dn && !tap_up) begin
            if (vote_r != VOTE_NEG_MAX) vote_nxt_s = vote_r - VOTE_ONE;
            else                        vote_nxt_s = vote_r;
        end else begin
            vote_nxt_s = vote_r;
        end
    end

    // Vote sign to direction, suppressing steps that would leave the coefficient range.
    always_comb begin
        dec_s = DIR_NONE;
        if (!tap_en) begin
            dec_s = DIR_NONE;
        end else if (!vote_r[VOTE_W-1] && (vote_r != VOTE_ZERO)) begin
            if (coef_r == C_MAX) dec_s = DIR_NONE;
            else                 dec_s = DIR_INC;
        end else if (vote_r[VOTE_W-1]) begin
            if (coef_r == C_MIN) dec_s = DIR_NONE;
            else                 dec_s = DIR_DEC;
        end else begin
            dec_s = DIR_NONE;
        end
    end

    // Next feedback, coefficient and saved step for report, undo and abort.
    always_comb begin
        dir_nxt_s  = dir_r;
        coef_nxt_s = coef_r;
        step_nxt_s = step_r;
        if (clr_fb || !tap_en) dir_nxt_s = DIR_NONE;
        else if (apply)        dir_nxt_s = dec_s;
        else if (undo)         dir_nxt_s = DIR_NONE;
        else                   dir_nxt_s = dir_r;

        if (apply) begin
            step_nxt_s = dec_s;
            case (dec_s)
                DIR_INC: coef_nxt_s = coef_r + COEF_ONE;
                DIR_DEC: coef_nxt_s = coef_r - COEF_ONE;
                default: coef_nxt_s = coef_r;
            endcase
        end else if (undo && revert) begin
            step_nxt_s = DIR_NONE;
            case (step_r)
                DIR_INC: coef_nxt_s = coef_r - COEF_ONE;
                DIR_DEC: coef_nxt_s = coef_r + COEF_ONE;
                default: coef_nxt_s = coef_r;
            endcase
        end else begin
            step_nxt_s = step_r;
            coef_nxt_s = coef_r;
        end
    end

    // Tap state registers; votes are cleared at evaluation start and counted in ACCUM.
    always_ff @(posedge clk) begin
        if (rst) begin
            vote_r <= VOTE_ZERO;
            dir_r  <= DIR_NONE;
            step_r <= DIR_NONE;
            coef_r <= C_INIT;
        end else begin
            if (clr_votes)            vote_r <= VOTE_ZERO;
            else if (accum && tap_en) vote_r <= vote_nxt_s;
            dir_r  <= dir_nxt_s;
            step_r <= step_nxt_s;
            coef_r <= coef_nxt_s;
        end
    end

    assign dir  = dir_r;
    assign coef = coef_r;

endmodule

// File: rtl/c3aibadapt_rxdp_txeq_ntap_sm.sv
// N-tap TX-equalisation feedback engine: FSM, window timer, iteration
// counter and edge detectors, with one tap slice per coefficient.
module c3aibadapt_rxdp_txeq_ntap_sm
    import c3aibadapt_rxdp_txeq_ntap_sm_pkg::*;
#(
    parameter int NTAP      = 3,
    parameter int PRESCALE  = 1024,
    parameter int VOTE_W    = 16,
    parameter int COEF_W    = 6,
    parameter int COEF_INIT = 20,
    parameter int COEF_MIN  = 0,
    parameter int COEF_MAX  = 63
) (
    input logic                           rx_clock_txeq_clk,
    input logic                           rx_reset_txeq_clk_rst,
    c3aibadapt_rxdp_txeq_ntap_sm_if.slave bus
);

    localparam int TMR_W = txeq_tmr_w(PRESCALE);
    localparam int PS_W  = $clog2(PRESCALE);
    localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};

    txeq_state_e              state_r;
    txeq_state_e              next_state_s;
    logic                     eval_prev_r;
    logic                     inv_prev_r;
    logic [TMR_W-1:0]         tmr_r;
    logic [1:0]               iter_r;
    logic [TMR_W-1:0]         win_m1_s;
    logic                     active_s;
    logic                     eval_rise_s;
    logic                     inv_rise_s;
    logic                     expire_s;
    logic                     start_s;
    logic                     reload_s;
    logic                     set_timeout_s;
    logic                     apply_s;
    logic                     undo_s;
    logic                     phystatus_r;
    logic                     accum_r;
    logic                     timeout_r;
    logic [NTAP-1:0][1:0]     dir_s;
    logic [NTAP-1:0][COEF_W-1:0] coef_s;

    // Window length in clock cycles minus one; the prescale is folded into the timer.
    assign win_m1_s    = {bus.r_rx_txeq_time, {PS_W{1'b0}}} - TMR_ONE;
    assign active_s    = bus.rxeqinprogress && bus.r_rx_txeq_en;
    assign eval_rise_s = bus.rxeqeval && !eval_prev_r;
    assign inv_rise_s  = bus.invalid_req && !inv_prev_r;
    assign expire_s    = (state_r == ST_ACCUM) && (bus.r_rx_txeq_time != 8'd0) && (tmr_r == TMR_ZERO);
    assign apply_s     = (state_r == ST_DECIDE) && active_s;
    // An evaluation start in the same cycle takes precedence over invalid_req.
    assign undo_s      = active_s && inv_rise_s && !eval_rise_s &&
                         ((state_r == ST_IDLE) || (state_r == ST_HOLD));

    // Next-state logic with abort to IDLE whenever the phase or engine is disabled.
    always_comb begin
        next_state_s  = state_r;
        start_s       = 1'b0;
        reload_s      = 1'b0;
        set_timeout_s = 1'b0;
        if (!active_s) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (eval_rise_s) begin
                        next_state_s = ST_ACCUM;
                        start_s      = 1'b1;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    if (expire_s) begin
                        if (iter_r == 2'd0) begin
                            next_state_s  = ST_DECIDE;
                            set_timeout_s = 1'b1;
                        end else begin
                            next_state_s = ST_ACCUM;
                            reload_s     = 1'b1;
                        end
                    end else if (!bus.rxeqeval) begin
                        next_state_s = ST_DECIDE;
                    end else begin
                        next_state_s = ST_ACCUM;
                    end
                end
                ST_DECIDE: next_state_s = ST_REPORT;
                ST_REPORT: next_state_s = ST_HOLD;
                ST_HOLD: begin
                    if (!bus.rxeqeval) next_state_s = ST_IDLE;
                    else               next_state_s = ST_HOLD;
                end
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // State register and input edge detectors.
    always_ff @(posedge rx_clock_txeq_clk) begin
        if (rx_reset_txeq_clk_rst) begin
            state_r     <= ST_IDLE;
            eval_prev_r <= 1'b0;
            inv_prev_r  <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            eval_prev_r <= bus.rxeqeval;
            inv_prev_r  <= bus.invalid_req;
        end
    end

    // Window timer and remaining-iteration counter.
    always_ff @(posedge rx_clock_txeq_clk) begin
        if (rx_reset_txeq_clk_rst) begin
            tmr_r  <= TMR_ZERO;
            iter_r <= 2'd0;
        end else if (start_s) begin
            tmr_r  <= win_m1_s;
            iter_r <= bus.r_rx_eq_iteration;
        end else if (reload_s) begin
            tmr_r  <= win_m1_s;
            iter_r <= iter_r - 2'd1;
        end else if ((state_r == ST_ACCUM) && (tmr_r != TMR_ZERO)) begin
            tmr_r  <= tmr_r - TMR_ONE;
        end
    end

    // Registered status outputs; timeout is sticky until the next evaluation start.
    always_ff @(posedge rx_clock_txeq_clk) begin
        if (rx_reset_txeq_clk_rst) begin
            phystatus_r <= 1'b0;
            accum_r     <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            phystatus_r <= (next_state_s == ST_REPORT);
            accum_r     <= (next_state_s == ST_ACCUM);
            if (start_s)            timeout_r <= 1'b0;
            else if (set_timeout_s) timeout_r <= 1'b1;
        end
    end

    for (genvar k = 0; k < NTAP; k++) begin : g_tap
        c3aibadapt_rxdp_txeq_tap #(
            .VOTE_W    (VOTE_W),
            .COEF_W    (COEF_W),
            .COEF_INIT (COEF_INIT),
            .COEF_MIN  (COEF_MIN),
            .COEF_MAX  (COEF_MAX)
        ) u_tap (
            .clk       (rx_clock_txeq_clk),
            .rst       (rx_reset_txeq_clk_rst),
            .tap_en    (bus.r_rx_tap_en[k]),
            .tap_up    (bus.tap_up[k]),
            .tap_dn    (bus.tap_dn[k]),
            .clr_votes (start_s),
            .accum     (state_r == ST_ACCUM),
            .apply     (apply_s),
            .clr_fb    (!active_s),
            .undo      (undo_s),
            .revert    (!bus.r_rx_invalid_no_change),
            .dir       (dir_s[k]),
            .coef      (coef_s[k])
        );
    end

    assign bus.pma_tx_accum = accum_r;
    assign bus.phystatus    = phystatus_r;
    assign bus.timeout      = timeout_r;
    assign bus.st           = state_r;
    assign bus.dirfeedback  = dir_s;
    assign bus.coef         = coef_s;

endmodule

// File: tb/tb_c3aibadapt_rxdp_txeq_ntap_sm.sv
// Directed bench for the N-tap txeq engine with PRESCALE=4.
module tb_c3aibadapt_rxdp_txeq_ntap_sm;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    c3aibadapt_rxdp_txeq_ntap_sm_if #(.NTAP(3), .COEF_W(6)) bus ();

    c3aibadapt_rxdp_txeq_ntap_sm #(
        .NTAP(3), .PRESCALE(4), .VOTE_W(16), .COEF_W(6),
        .COEF_INIT(20), .COEF_MIN(0), .COEF_MAX(63)
    ) dut (
        .rx_clock_txeq_clk     (clk),
        .rx_reset_txeq_clk_rst (rst),
        .bus                   (bus.slave)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst                        = 1'b1;
        bus.r_rx_txeq_en           = 1'b1;
        bus.r_rx_tap_en            = 3'b111;
        bus.r_rx_invalid_no_change = 1'b0;
        bus.r_rx_eq_iteration      = 2'd1;
        bus.r_rx_txeq_time         = 8'd2;
        bus.rxeqinprogress         = 1'b1;
        bus.rxeqeval               = 1'b0;
        bus.invalid_req            = 1'b0;
        bus.tap_up                 = 3'b000;
        bus.tap_dn                 = 3'b000;
        step(3);
        check("rst_st",   bus.st, 3'd0);
        check("rst_coef", bus.coef, {6'd20, 6'd20, 6'd20});
        check("rst_df",   bus.dirfeedback, 6'b000000);
        check("rst_phy",  bus.phystatus, 1'b0);
        check("rst_acc",  bus.pma_tx_accum, 1'b0);
        check("rst_to",   bus.timeout, 1'b0);
        rst = 1'b0;
        step(1);

        // Timed eval: W=8, I=2 -> phystatus at n+18
        bus.tap_up   = 3'b001;
        bus.tap_dn   = 3'b100;
        bus.rxeqeval = 1'b1;
        step(1);
        check("t1_acc_on", bus.pma_tx_accum, 1'b1);
        check("t1_st_acc", bus.st, 3'd1);
        step(16);
        check("t1_decide_st", bus.st, 3'd2);
        check("t1_phy_early", bus.phystatus, 1'b0);
        check("t1_acc_off",   bus.pma_tx_accum, 1'b0);
        step(1);
        check("t1_phy",  bus.phystatus, 1'b1);
        check("t1_df",   bus.dirfeedback, 6'b10_00_01);
        check("t1_coef", bus.coef, {6'd19, 6'd20, 6'd21});
        check("t1_to",   bus.timeout, 1'b1);
        step(1);
        check("t1_hold_st",  bus.st, 3'd4);
        check("t1_hold_phy", bus.phystatus, 1'b0);
        check("t1_hold_df",  bus.dirfeedback, 6'b10_00_01);
        bus.rxeqeval = 1'b0;
        bus.tap_up   = 3'b000;
        bus.tap_dn   = 3'b000;
        step(1);
        check("t1_idle_st", bus.st, 3'd0);
        check("t1_idle_df", bus.dirfeedback, 6'b10_00_01);

        // Invalid with undo: both saved steps revert
        bus.invalid_req = 1'b1;
        step(1);
        bus.invalid_req = 1'b0;
        check("undo_df",   bus.dirfeedback, 6'b000000);
        check("undo_coef", bus.coef, {6'd20, 6'd20, 6'd20});

        // Early drop, untimed: 5 cycles of tap0 down votes
        bus.r_rx_txeq_time = 8'd0;
        bus.tap_dn         = 3'b001;
        bus.rxeqeval       = 1'b1;
        step(5);
        bus.rxeqeval = 1'b0;
        step(1);
        check("t2_decide_st", bus.st, 3'd2);
        check("t2_phy_early", bus.phystatus, 1'b0);
        step(1);
        check("t2_phy",  bus.phystatus, 1'b1);
        check("t2_df",   bus.dirfeedback, 6'b00_00_10);
        check("t2_to",   bus.timeout, 1'b0);
        check("t2_coef", bus.coef, {6'd20, 6'd20, 6'd19});
        bus.tap_dn = 3'b000;
        step(3);

        // Invalid with no_change: feedback cleared, coefficients kept
        bus.r_rx_invalid_no_change = 1'b1;
        bus.invalid_req            = 1'b1;
        step(1);
        bus.invalid_req            = 1'b0;
        bus.r_rx_invalid_no_change = 1'b0;
        check("nochg_df",   bus.dirfeedback, 6'b000000);
        check("nochg_coef", bus.coef, {6'd20, 6'd20, 6'd19});

        // Disabled tap 1 with active votes
        bus.r_rx_tap_en = 3'b101;
        bus.tap_up      = 3'b011;
        bus.rxeqeval    = 1'b1;
        step(3);
        bus.rxeqeval = 1'b0;
        step(2);
        check("dis_phy",  bus.phystatus, 1'b1);
        check("dis_df",   bus.dirfeedback, 6'b00_00_01);
        check("dis_coef", bus.coef, {6'd20, 6'd20, 6'd20});
        bus.tap_up = 3'b000;
        step(3);
        bus.r_rx_tap_en = 3'b111;

        // Abort mid-ACCUM via rxeqinprogress
        bus.rxeqeval = 1'b1;
        step(3);
        check("ab_st_acc", bus.st, 3'd1);
        check("ab_acc_on", bus.pma_tx_accum, 1'b1);
        bus.rxeqinprogress = 1'b0;
        step(1);
        check("ab_st",  bus.st, 3'd0);
        check("ab_acc", bus.pma_tx_accum, 1'b0);
        check("ab_df",  bus.dirfeedback, 6'b000000);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("ab_no_phy", bus.phystatus, 1'b0);
        end
        check("ab_coef", bus.coef, {6'd20, 6'd20, 6'd20});
        bus.rxeqinprogress = 1'b1;
        bus.rxeqeval       = 1'b0;
        step(2);

        // Sync reset mid-HOLD: W=4, I=1 -> phystatus at n+6
        bus.r_rx_txeq_time    = 8'd1;
        bus.r_rx_eq_iteration = 2'd0;
        bus.tap_dn            = 3'b100;
        bus.rxeqeval          = 1'b1;
        step(6);
        check("rh_phy", bus.phystatus, 1'b1);
        check("rh_df",  bus.dirfeedback, 6'b10_00_00);
        check("rh_to",  bus.timeout, 1'b1);
        step(1);
        check("rh_hold", bus.st, 3'd4);
        rst          = 1'b1;
        bus.rxeqeval = 1'b0;
        bus.tap_dn   = 3'b000;
        step(1);
        check("rh_st",   bus.st, 3'd0);
        check("rh_coef", bus.coef, {6'd20, 6'd20, 6'd20});
        check("rh_df0",  bus.dirfeedback, 6'b000000);
        check("rh_to0",  bus.timeout, 1'b0);
        check("rh_phy0", bus.phystatus, 1'b0);
        rst = 1'b0;
        step(1);

        // Saturation: drive coef0 from 20 to 63, then one more up-majority eval
        bus.r_rx_txeq_time = 8'd0;
        bus.tap_up         = 3'b001;
        repeat (43) begin
            bus.rxeqeval = 1'b1;
            step(1);
            bus.rxeqeval = 1'b0;
            step(5);
        end
        check("sat_coef_pre", bus.coef, {6'd20, 6'd20, 6'd63});
        bus.rxeqeval = 1'b1;
        step(1);
        bus.rxeqeval = 1'b0;
        step(2);
        check("sat_phy",  bus.phystatus, 1'b1);
        check("sat_df",   bus.dirfeedback, 6'b000000);
        check("sat_coef", bus.coef, {6'd20, 6'd20, 6'd63});
        bus.tap_up = 3'b000;
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
